// File: rtl/ariane_pkg.sv
// Shared types and decode helpers for the divider issue path.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [2:0] {
    DIV   = 3'd0,
    DIVU  = 3'd1,
    REM   = 3'd2,
    REMU  = 3'd3,
    DIVW  = 3'd4,
    DIVUW = 3'd5,
    REMW  = 3'd6,
    REMUW = 3'd7
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } div_fe_state_e;

  // 32-bit variant operating on the low word.
  function automatic logic is_w_op(input div_op_e op);
    return op inside {DIVW, DIVUW, REMW, REMUW};
  endfunction

  // Remainder rather than quotient.
  function automatic logic is_rem_op(input div_op_e op);
    return op inside {REM, REMU, REMW, REMUW};
  endfunction

  // Unsigned interpretation of the operands.
  function automatic logic is_unsigned_op(input div_op_e op);
    return op inside {DIVU, REMU, DIVUW, REMUW};
  endfunction

endpackage

// File: rtl/div_issue_frontend.sv
// Front end in front of the serial divider: decodes the request, prepares
// operands, short-cuts division by one and holds the result for writeback.
module div_issue_frontend #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     div_valid_i,
  output logic                     div_ready_o,
  input  logic [2:0]               operation_i,
  input  logic [WIDTH-1:0]         operand_a_i,
  input  logic [WIDTH-1:0]         operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     div_vld_o,
  input  logic                     div_rdy_i,
  output logic [WIDTH-1:0]         div_op_a_o,
  output logic [WIDTH-1:0]         div_op_b_o,
  output logic [1:0]               div_opcode_o,
  output logic [TRANS_ID_BITS-1:0] div_id_o,
  output logic                     div_flush_o,
  input  logic                     div_out_vld_i,
  output logic                     div_out_rdy_o,
  input  logic [WIDTH-1:0]         div_res_i,
  input  logic [TRANS_ID_BITS-1:0] div_id_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [WIDTH-1:0]         result_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o
);

  import ariane_pkg::*;

  // Word ops only exist on a 64-bit datapath.
  localparam logic             W_OK    = (WIDTH == 64);
  localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << 32;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  // Replace everything above bit 31 with the fill bit.
  function automatic logic [WIDTH-1:0] ext32(input logic [WIDTH-1:0] v, input logic fill);
    return (v & ~HI_MASK) | (fill ? HI_MASK : '0);
  endfunction

  // Operand preparation: word ops sign- or zero-extend the low word.
  function automatic logic [WIDTH-1:0] prep_operand(input logic [WIDTH-1:0] v,
                                                     input logic w, input logic sgn);
    return w ? ext32(v, sgn & v[31]) : v;
  endfunction

  div_fe_state_e            state_q, state_d;
  logic [TRANS_ID_BITS-1:0] id_q, id_d;
  logic [1:0]               opcode_q, opcode_d;
  logic                     w_q, w_d;
  logic [WIDTH-1:0]         op_a_q, op_a_d;
  logic [WIDTH-1:0]         op_b_q, op_b_d;
  logic [WIDTH-1:0]         result_q, result_d;

  div_op_e          req_op;
  logic             req_w, req_rem, req_sgn;
  logic [WIDTH-1:0] prep_a, prep_b;

  // Request decode and operand preparation.
  always_comb begin
    req_op  = div_op_e'(operation_i);
    req_w   = W_OK & is_w_op(req_op);
    req_rem = is_rem_op(req_op);
    req_sgn = ~is_unsigned_op(req_op);
    prep_a  = prep_operand(operand_a_i, req_w, req_sgn);
    prep_b  = prep_operand(operand_b_i, req_w, req_sgn);
  end

  // Next-state and output logic; flush overrides every state.
  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    opcode_d       = opcode_q;
    w_d            = w_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    result_d       = result_q;
    div_ready_o    = 1'b0;
    div_vld_o      = 1'b0;
    div_out_rdy_o  = 1'b0;
    result_valid_o = 1'b0;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          div_ready_o = 1'b1;
          if (div_valid_i) begin
            id_d     = trans_id_i;
            opcode_d = {req_rem, req_sgn};
            w_d      = req_w;
            if (prep_b == ONE) begin
              // x/1 = x, x%1 = 0: the divider is bypassed entirely.
              result_d = req_rem ? '0 : (req_w ? ext32(prep_a, prep_a[31]) : prep_a);
              state_d  = DONE;
            end else begin
              op_a_d  = prep_a;
              op_b_d  = prep_b;
              state_d = ISSUE;
            end
          end
        end
        ISSUE: begin
          div_vld_o = 1'b1;
          state_d   = BUSY;
        end
        BUSY: begin
          div_out_rdy_o = 1'b1;
          if (div_out_vld_i) begin
            result_d = w_q ? ext32(div_res_i, div_res_i[31]) : div_res_i;
            state_d  = DONE;
          end
        end
        DONE: begin
          result_valid_o = 1'b1;
          if (result_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      id_q     <= '0;
      opcode_q <= '0;
      w_q      <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      opcode_q <= opcode_d;
      w_q      <= w_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
    end
  end

  assign div_op_a_o        = op_a_q;
  assign div_op_b_o        = op_b_q;
  assign div_opcode_o      = opcode_q;
  assign div_id_o          = id_q;
  assign div_flush_o       = flush_i;
  assign result_o          = result_q;
  assign result_trans_id_o = id_q;

  // The divider returns the id it was given for the single op in flight.
  a_id_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == BUSY && div_out_vld_i && !flush_i) |-> (div_id_i == id_q));

  // With one op in flight the divider is always free when we issue.
  a_div_free: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ISSUE) |-> div_rdy_i);

endmodule
